// File: rtl/alu_sweep_capture.sv
// Drives an external ALU through every opcode with one latched operand set,
// captures each settled result, then streams (opcode, R) pairs over valid/ready.
module alu_sweep_capture #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 4,
    parameter int NUM_OPS = 16,
    parameter int SETTLE  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             m_in,
    input  logic             cn_in,
    input  logic             l_in,
    input  logic             h_in,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    output logic             alu_m,
    output logic             alu_cn,
    output logic             alu_l,
    output logic             alu_h,
    input  logic [WIDTH-1:0] alu_r,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_opcode,
    output logic [WIDTH-1:0] out_r,
    output logic             out_last,
    output logic             done
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DUMP} state_t;

    state_t           state_reg;
    logic [SW-1:0]    settle_cnt_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    rd_ptr_next;
    logic [PW-1:0]    wr_addr;
    logic             capture;
    logic             last_op;
    logic             handshake;
    logic [WIDTH-1:0] mem [NUM_OPS];

    assign wr_addr     = alu_opcode[PW-1:0];
    assign capture     = (state_reg == SWEEP) && (settle_cnt_reg == SW'(SETTLE - 1));
    assign last_op     = (alu_opcode == OPW'(NUM_OPS - 1));
    assign handshake   = (state_reg == DUMP) && out_valid && out_ready;
    assign rd_ptr_next = rd_ptr_reg + PW'(1);

    // Result buffer kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_addr] <= alu_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            settle_cnt_reg <= '0;
            rd_ptr_reg     <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_opcode     <= '0;
            alu_m          <= 1'b0;
            alu_cn         <= 1'b0;
            alu_l          <= 1'b0;
            alu_h          <= 1'b0;
            busy           <= 1'b0;
            out_valid      <= 1'b0;
            out_opcode     <= '0;
            out_r          <= '0;
            out_last       <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        alu_a          <= a_in;
                        alu_b          <= b_in;
                        alu_m          <= m_in;
                        alu_cn         <= cn_in;
                        alu_l          <= l_in;
                        alu_h          <= h_in;
                        alu_opcode     <= '0;
                        settle_cnt_reg <= '0;
                        busy           <= 1'b1;
                        state_reg      <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (capture) begin
                        if (last_op) begin
                            // First entry is presented straight away; with a single
                            // opcode it is the value being written this very edge.
                            state_reg  <= DUMP;
                            rd_ptr_reg <= '0;
                            out_valid  <= 1'b1;
                            out_opcode <= '0;
                            out_r      <= (NUM_OPS == 1) ? alu_r : mem[PW'(0)];
                            out_last   <= (NUM_OPS == 1);
                        end else begin
                            alu_opcode     <= alu_opcode + OPW'(1);
                            settle_cnt_reg <= '0;
                        end
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + SW'(1);
                    end
                end
                DUMP: begin
                    if (handshake) begin
                        if (out_last) begin
                            state_reg <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            rd_ptr_reg <= rd_ptr_next;
                            out_opcode <= OPW'(rd_ptr_next);
                            out_r      <= mem[rd_ptr_next];
                            out_last   <= (rd_ptr_next == PW'(NUM_OPS - 1));
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sweep_capture.sv
// Directed bench for alu_sweep_capture: a default instance plus a SETTLE=1,
// NUM_OPS=4 instance, each driving a stub ALU computing a + b + opcode.
module tb_alu_sweep_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic       m_in = 0, cn_in = 0, l_in = 0, h_in = 0;
    logic [7:0] alu_a, alu_b, alu_r, out_r;
    logic [3:0] alu_opcode, out_opcode;
    logic       alu_m, alu_cn, alu_l, alu_h, busy, out_valid, out_last, done;

    logic       c_start = 1'b0, c_out_ready = 1'b0;
    logic [7:0] c_alu_a, c_alu_b, c_alu_r, c_out_r;
    logic [3:0] c_alu_opcode, c_out_opcode;
    logic       c_alu_m, c_alu_cn, c_alu_l, c_alu_h, c_busy, c_out_valid, c_out_last, c_done;

    assign alu_r   = alu_a + alu_b + {4'h0, alu_opcode};
    assign c_alu_r = c_alu_a + c_alu_b + {4'h0, c_alu_opcode};

    alu_sweep_capture dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .m_in(m_in), .cn_in(cn_in), .l_in(l_in), .h_in(h_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_m(alu_m), .alu_cn(alu_cn), .alu_l(alu_l), .alu_h(alu_h), .alu_r(alu_r),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_r(out_r), .out_last(out_last), .done(done)
    );

    alu_sweep_capture #(.WIDTH(8), .OPW(4), .NUM_OPS(4), .SETTLE(1)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .a_in(8'h10), .b_in(8'h05),
        .m_in(1'b0), .cn_in(1'b1), .l_in(1'b0), .h_in(1'b1),
        .alu_a(c_alu_a), .alu_b(c_alu_b), .alu_opcode(c_alu_opcode),
        .alu_m(c_alu_m), .alu_cn(c_alu_cn), .alu_l(c_alu_l), .alu_h(c_alu_h), .alu_r(c_alu_r),
        .busy(c_busy), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_opcode(c_out_opcode), .out_r(c_out_r), .out_last(c_out_last), .done(c_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] ctrl);
        @(negedge clk);
        a_in = a; b_in = b;
        {m_in, cn_in, l_in, h_in} = ctrl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // n counts falling edges after the start edge; opcode k is expected for n in [10k, 10k+9].
    task automatic sweep(input int inject_at, input int rst_at, input logic [7:0] exp_a);
        for (int n = 0; n < 160; n++) begin
            start = 1'b0;
            if (n % 10 == 0) check("op_hold_first", alu_opcode, n / 10);
            if (n % 10 == 9) check("op_hold_last", alu_opcode, n / 10);
            if (n == inject_at) begin
                start = 1'b1;
                a_in  = 8'hFF;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("sweep_rst_busy", busy, 0);
                check("sweep_rst_alu_a", alu_a, 0);
                check("sweep_rst_opcode", alu_opcode, 0);
                check("sweep_rst_valid", out_valid, 0);
                @(negedge clk);
                check("sweep_rst_no_done", done, 0);
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("dump_entry_valid", out_valid, 1);
        check("alu_a_held", alu_a, exp_a);
        check("alu_ctrl_held", {alu_m, alu_cn, alu_l, alu_h}, 4'b1010);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
    task automatic dump(input int mode, input int abort_after, input logic [7:0] base);
        int idx = 0;
        int cyc = 0;
        while (idx < 16 && cyc < 400) begin
            if (idx == abort_after) begin
                out_ready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("dump_rst_valid", out_valid, 0);
                check("dump_rst_busy", busy, 0);
                check("dump_rst_done", done, 0);
                @(negedge clk);
                check("dump_rst_no_done", done, 0);
                return;
            end
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            check("dump_valid", out_valid, 1);
            check("dump_opcode", out_opcode, idx);
            check("dump_r", out_r, 8'(base + 8'(idx)));
            check("dump_last", out_last, (idx == 15));
            check("dump_busy", busy, 1);
            if (out_ready && out_valid) begin
                $display("dump op=%0d r=%02h last=%0b", out_opcode, out_r, out_last);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        check("dump_count", idx, 16);
        out_ready = 1'b0;
        check("done_pulse", done, 1);
        check("post_dump_valid", out_valid, 0);
        check("post_dump_busy", busy, 0);
        @(negedge clk);
        check("done_single", done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outputs",
                  {alu_a, alu_b, alu_opcode, alu_m, alu_cn, alu_l, alu_h,
                   busy, out_valid, out_opcode, out_last, done}, 0);
            check("idle_out_r", out_r, 0);
        end

        $display("test basic sweep");
        start_sweep(8'h01, 8'h02, 4'b1010);
        sweep(-1, -1, 8'h01);
        dump(0, -1, 8'h03);

        $display("test backpressure");
        start_sweep(8'h01, 8'h02, 4'b1010);
        sweep(-1, -1, 8'h01);
        dump(1, -1, 8'h03);

        $display("test start while busy");
        start_sweep(8'h01, 8'h02, 4'b1010);
        sweep(50, -1, 8'h01);
        dump(0, -1, 8'h03);

        $display("test reset mid-operation");
        start_sweep(8'h01, 8'h02, 4'b1010);
        sweep(-1, 73, 8'h01);
        start_sweep(8'h01, 8'h02, 4'b1010);
        sweep(-1, -1, 8'h01);
        dump(0, 5, 8'h03);
        start_sweep(8'h01, 8'h02, 4'b1010);
        sweep(-1, -1, 8'h01);
        dump(0, -1, 8'h03);

        $display("test SETTLE=1 NUM_OPS=4");
        @(negedge clk);
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("c_sweep_opcode", c_alu_opcode, n);
            check("c_sweep_not_valid", c_out_valid, 0);
            @(negedge clk);
        end
        begin
            int idx = 0;
            int cyc = 0;
            c_out_ready = 1'b1;
            while (idx < 4 && cyc < 20) begin
                check("c_dump_valid", c_out_valid, 1);
                check("c_dump_opcode", c_out_opcode, idx);
                check("c_dump_r", c_out_r, 8'(8'h15 + 8'(idx)));
                check("c_dump_last", c_out_last, (idx == 3));
                if (c_out_valid) begin
                    $display("c_dump op=%0d r=%02h last=%0b", c_out_opcode, c_out_r, c_out_last);
                    idx++;
                end
                @(negedge clk);
                cyc++;
            end
            check("c_dump_count", idx, 4);
            c_out_ready = 1'b0;
            check("c_done_pulse", c_done, 1);
            check("c_post_valid", c_out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sweep_capture.md
Name: alu_sweep_capture

Overview:
- Synthesizable hardware counterpart to the ALU opcode-sweep stimulus flow.
- On `start`, it latches one operand/control set and drives an external ALU through all opcodes 0..NUM_OPS-1.
- After SETTLE cycles per opcode, it captures R into an internal buffer.
- After the sweep, it streams the captured (opcode, R) pairs to a reader over a valid/ready interface.
- Sits between the ALU and any on-chip logger or host reader.

Parameters:
- WIDTH, 8: operand and result width.
- OPW, 4: opcode width.
- NUM_OPS, 16: opcodes swept, 0..NUM_OPS-1. Must be ≤ 2**OPW.
- SETTLE, 10: cycles each opcode is held before R is sampled. Must be ≥ 1.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- a_in  in  WIDTH  operand A, latched on accepted start.
- b_in  in  WIDTH  operand B, latched on accepted start.
- m_in, cn_in, l_in, h_in  in  1 each  ALU mode/carry/control bits, latched on accepted start.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_opcode  out  OPW  registered opcode to the ALU.
- alu_m, alu_cn, alu_l, alu_h  out  1 each  registered control bits to the ALU.
- alu_r  in  WIDTH  ALU result; treated as combinational from the alu_* outputs.
- busy  out  1  high in SWEEP and DUMP.
- out_valid  out  1  a captured entry is presented.
- out_ready  in  1  the reader accepts the entry.
- out_opcode  out  OPW  opcode of the presented entry.
- out_r  out  WIDTH  captured R for that opcode.
- out_last  out  1  presented entry is the final one (opcode NUM_OPS-1).
- done  out  1  one-cycle pulse on the cycle after the final handshake.

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE.
  - All alu_* outputs 0; busy, out_valid, out_last, done 0; out_opcode, out_r 0.
  - Internal counters 0.
  - Buffer contents are don't-care.
  - rst has priority over every other input in the same cycle.
- State IDLE:
  - busy=0.
  - When start=1 at an edge:
    - latch a_in, b_in and the control bits onto alu_*;
    - set alu_opcode=0 and settle_cnt=0;
    - go to SWEEP.
- State SWEEP:
  - busy=1 from the first cycle after start.
  - settle_cnt increments each cycle.
  - At the edge where settle_cnt==SETTLE-1:
    - mem[alu_opcode] <= alu_r;
    - if alu_opcode==NUM_OPS-1: go to DUMP with rd_ptr=0;
    - else: alu_opcode <= alu_opcode+1 and settle_cnt <= 0.
  - Each opcode is therefore held exactly SETTLE cycles.
  - A full sweep lasts NUM_OPS*SETTLE cycles (160 at defaults) from the start edge to DUMP entry.
  - alu_a, alu_b and the control bits hold constant for the whole sweep.
- State DUMP:
  - out_valid=1.
  - out_opcode=rd_ptr, out_r=mem[rd_ptr], out_last=(rd_ptr==NUM_OPS-1). All are registered and stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: rd_ptr increments.
  - On the handshake with out_last=1:
    - go to IDLE;
    - out_valid=0 next cycle;
    - done=1 for exactly that next cycle.
  - Back-to-back handshakes are supported: one entry per cycle when out_ready is held high, so a dump takes NUM_OPS cycles minimum.
- start while busy: ignored, with no effect on state, counters or latched operands.
- start in the same cycle done pulses: accepted (state is IDLE), and a new sweep begins.
- alu_* outputs keep their last values in DUMP and IDLE until the next accepted start.
- rst mid-SWEEP or mid-DUMP: immediate return to IDLE with all reset values. A partial dump is abandoned and done is not pulsed.
- Counter widths:
  - settle_cnt wide enough for SETTLE-1;
  - rd_ptr wide enough for NUM_OPS-1;
  - no wrap-around is used; terminal compares govern all transitions.

Test Plan:
- Reset/idle: rst high 3 cycles, then idle 5 cycles with start=0 → every output 0, busy=0, no done.
- Basic sweep:
  - Stub ALU: alu_r = alu_a + alu_b + alu_opcode. Stimulus A=0x01, B=0x02, m=1, cn=0, l=1, h=0, start pulsed; out_ready held 1.
  - Required: alu_opcode steps 0..15, each held 10 cycles; busy asserts the cycle after start.
  - Required: 16 handshakes with (opcode i, R=0x03+i), 0x03..0x12; out_last only on opcode 15.
  - Required: done pulses once.
- Backpressure: same as the basic sweep, but out_ready toggles 1,0,0,1,... → each entry is held unchanged while stalled; no entry is skipped or duplicated; order is 0..15.
- Start while busy: pulse start again at sweep cycle 50 with A=0xFF → ignored; alu_a stays 0x01 and results match the basic sweep.
- Reset mid-operation: assert rst at sweep cycle 73, then in DUMP after 5 handshakes → both return to IDLE with out_valid=0 and no done. A fresh start then completes a full 16-entry dump.
- Parameter corner: SETTLE=1, NUM_OPS=4 → sweep takes 4 cycles; dump yields opcodes 0..3 with the correct stub R values; out_last on opcode 3.
